// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI3 read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Bundles both requester read ports and the shared memory-side read port.
interface axi_read_arbiter_if #(
    parameter int ADDR_W = axi_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = axi_arb_pkg::DEF_DATA_W,
    parameter int LEN_W  = axi_arb_pkg::DEF_LEN_W
) ();
    logic [ADDR_W-1:0] r0_araddr, r1_araddr;
    logic [LEN_W-1:0]  r0_arlen, r1_arlen;
    logic              r0_arvalid, r1_arvalid;
    logic              r0_arready, r1_arready;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic              r0_rlast, r1_rlast;
    logic              r0_rvalid, r1_rvalid;
    logic              r0_rready, r1_rready;

    logic [ADDR_W-1:0] m_araddr;
    logic [LEN_W-1:0]  m_arlen;
    logic              m_arvalid, m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rlast, m_rvalid, m_rready;

    // Arbiter view: target of the requesters, initiator toward memory.
    modport slave (
        input  r0_araddr, r1_araddr, r0_arlen, r1_arlen, r0_arvalid, r1_arvalid,
        input  r0_rready, r1_rready,
        output r0_arready, r1_arready, r0_rdata, r1_rdata, r0_rlast, r1_rlast,
        output r0_rvalid, r1_rvalid,
        output m_araddr, m_arlen, m_arvalid, m_rready,
        input  m_arready, m_rdata, m_rlast, m_rvalid
    );

    // Environment view: the cache controllers plus the memory port.
    modport master (
        output r0_araddr, r1_araddr, r0_arlen, r1_arlen, r0_arvalid, r1_arvalid,
        output r0_rready, r1_rready,
        input  r0_arready, r1_arready, r0_rdata, r1_rdata, r0_rlast, r1_rlast,
        input  r0_rvalid, r1_rvalid,
        input  m_araddr, m_arlen, m_arvalid, m_rready,
        output m_arready, m_rdata, m_rlast, m_rvalid
    );
endinterface

// File: rtl/axi_read_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       pick,
    output logic       any
);
    always_comb begin
        any  = |valid;
        pick = 1'b0;
        if (valid == 2'b11) begin
            pick = ~last_grant;
        end else if (valid[1] && !valid[0]) begin
            pick = 1'b1;
        end
    end
endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read port between I-cache (req 0) and D-cache (req 1) refills,
// one burst at a time, with flush-driven draining of I-side bursts.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    axi_read_arbiter_if.slave  bus,
    input  logic               flush,
    output logic [1:0]         grant,
    output logic               protocol_err
);
    state_t            state_reg;
    logic              owner_reg;
    logic              last_grant_reg;
    logic              drain_reg;
    logic              err_reg;
    logic              m_arvalid_reg;
    logic [1:0]        grant_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  beat_cnt_reg;

    logic pick, any, in_data, drain, owner_rready, beat, accept;

    rr_arbiter_2 u_rr (
        .valid      ({bus.r1_arvalid, bus.r0_arvalid}),
        .last_grant (last_grant_reg),
        .pick       (pick),
        .any        (any)
    );

    // Gating with rst keeps arready low while reset is held, even though state is IDLE.
    assign accept  = rst && (state_reg == IDLE) && any;
    assign in_data = (state_reg == DATA);
    // A flush in the same cycle takes effect at once, before drain_reg catches up.
    assign drain   = drain_reg ||
                     (flush && (state_reg != IDLE) && (owner_reg == REQ_ICACHE));
    assign owner_rready = owner_reg ? bus.r1_rready : bus.r0_rready;
    assign beat    = in_data && bus.m_rvalid && bus.m_rready;

    assign bus.r0_arready = accept && (pick == REQ_ICACHE);
    assign bus.r1_arready = accept && (pick == REQ_DCACHE);

    assign bus.m_araddr  = addr_reg;
    assign bus.m_arlen   = len_reg;
    assign bus.m_arvalid = m_arvalid_reg;
    assign bus.m_rready  = in_data && (drain || owner_rready);

    assign bus.r0_rvalid = in_data && (owner_reg == REQ_ICACHE) && bus.m_rvalid && !drain;
    assign bus.r1_rvalid = in_data && (owner_reg == REQ_DCACHE) && bus.m_rvalid;
    assign bus.r0_rdata  = (in_data && owner_reg == REQ_ICACHE) ? bus.m_rdata : '0;
    assign bus.r1_rdata  = (in_data && owner_reg == REQ_DCACHE) ? bus.m_rdata : '0;
    assign bus.r0_rlast  = in_data && (owner_reg == REQ_ICACHE) && bus.m_rlast;
    assign bus.r1_rlast  = in_data && (owner_reg == REQ_DCACHE) && bus.m_rlast;

    assign grant        = grant_reg;
    assign protocol_err = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= REQ_ICACHE;
            last_grant_reg <= REQ_DCACHE;
            drain_reg      <= 1'b0;
            err_reg        <= 1'b0;
            m_arvalid_reg  <= 1'b0;
            grant_reg      <= 2'b00;
            addr_reg       <= '0;
            len_reg        <= '0;
            beat_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any) begin
                        state_reg     <= ADDR;
                        owner_reg     <= pick;
                        addr_reg      <= pick ? bus.r1_araddr : bus.r0_araddr;
                        len_reg       <= pick ? bus.r1_arlen : bus.r0_arlen;
                        beat_cnt_reg  <= '0;
                        grant_reg     <= id_to_onehot(pick);
                        m_arvalid_reg <= 1'b1;
                    end
                end
                ADDR: begin
                    drain_reg <= drain;
                    if (bus.m_arready) begin
                        m_arvalid_reg <= 1'b0;
                        state_reg     <= DATA;
                    end
                end
                DATA: begin
                    drain_reg <= drain;
                    if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        if (bus.m_rlast) begin
                            if (beat_cnt_reg != len_reg) err_reg <= 1'b1;
                            state_reg      <= IDLE;
                            grant_reg      <= 2'b00;
                            last_grant_reg <= owner_reg;
                            drain_reg      <= 1'b0;
                        end else if (beat_cnt_reg == len_reg) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: inputs change on the falling edge, outputs checked 1ns later.
module tb_axi_read_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic [1:0] grant;
    logic protocol_err;
    int checks = 0;
    int failures = 0;

    axi_read_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

    axi_read_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .flush        (flush),
        .grant        (grant),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.r0_araddr = '0; bus.r1_araddr = '0; bus.r0_arlen = '0; bus.r1_arlen = '0;
        bus.r0_arvalid = 1'b0; bus.r1_arvalid = 1'b0;
        bus.r0_rready = 1'b0; bus.r1_rready = 1'b0;
        bus.m_arready = 1'b0; bus.m_rdata = '0; bus.m_rlast = 1'b0; bus.m_rvalid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        bus.r0_arvalid = 1'b1; bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; flush = 1'b1;
        #1;
        checks++; if (bus.r0_arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%b exp=0", bus.r0_arready); end
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (bus.m_arvalid !== 1'b0 || bus.m_rready !== 1'b0) begin failures++; $display("FAIL reset_m got arvalid=%b rready=%b exp=0,0", bus.m_arvalid, bus.m_rready); end
        checks++; if (protocol_err !== 1'b0 || bus.r0_rvalid !== 1'b0) begin failures++; $display("FAIL reset_err_rvalid got err=%b rvalid=%b exp=0,0", protocol_err, bus.r0_rvalid); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        $display("txn reset done");
    endtask

    task automatic test_basic();
        @(negedge clk);
        bus.r0_arvalid = 1'b1; bus.r0_araddr = 32'h100; bus.r0_arlen = 4'd3;
        #1;
        checks++; if (bus.r0_arready !== 1'b1 || bus.r1_arready !== 1'b0) begin failures++; $display("FAIL basic_arready got r0=%b r1=%b exp=1,0", bus.r0_arready, bus.r1_arready); end
        @(negedge clk);
        bus.r0_arvalid = 1'b0; bus.m_arready = 1'b1;
        #1;
        checks++; if (bus.m_arvalid !== 1'b1) begin failures++; $display("FAIL basic_m_arvalid got=%b exp=1", bus.m_arvalid); end
        checks++; if (bus.m_araddr !== 32'h100 || bus.m_arlen !== 4'd3) begin failures++; $display("FAIL basic_addr got=%h/%0d exp=100/3", bus.m_araddr, bus.m_arlen); end
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL basic_grant got=%b exp=01", grant); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hA000_0000 + i;
            bus.m_rlast = (i == 3); bus.r0_rready = 1'b1;
            #1;
            checks++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 32'hA000_0000 + i) begin failures++; $display("FAIL basic_beat%0d got v=%b d=%h exp v=1 d=%h", i, bus.r0_rvalid, bus.r0_rdata, 32'hA000_0000 + i); end
            checks++; if (bus.r1_rvalid !== 1'b0 || bus.m_rready !== 1'b1) begin failures++; $display("FAIL basic_route%0d got r1v=%b mrr=%b exp=0,1", i, bus.r1_rvalid, bus.m_rready); end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (grant !== 2'b00 || protocol_err !== 1'b0) begin failures++; $display("FAIL basic_end got grant=%b err=%b exp=00,0", grant, protocol_err); end
        $display("txn basic r0 burst addr=0x100 len=3 done");
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk);
        bus.r0_arvalid = 1'b1; bus.r0_araddr = 32'h400; bus.r1_arvalid = 1'b1; bus.r1_araddr = 32'h800;
        #1;
        checks++; if (bus.r0_arready !== 1'b1 || bus.r1_arready !== 1'b0) begin failures++; $display("FAIL rr_first got r0=%b r1=%b exp=1,0", bus.r0_arready, bus.r1_arready); end
        @(negedge clk);
        bus.r0_arvalid = 1'b0; bus.m_arready = 1'b1;
        #1;
        checks++; if (bus.r1_arready !== 1'b0) begin failures++; $display("FAIL rr_busy_arready got=%b exp=0", bus.r1_arready); end
        @(negedge clk);
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 32'h11; bus.r0_rready = 1'b1;
        #1;
        checks++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rlast !== 1'b1) begin failures++; $display("FAIL rr_beat0 got v=%b l=%b exp=1,1", bus.r0_rvalid, bus.r0_rlast); end
        @(negedge clk);
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.r0_arvalid = 1'b1;
        #1;
        checks++; if (bus.r1_arready !== 1'b1 || bus.r0_arready !== 1'b0) begin failures++; $display("FAIL rr_second got r0=%b r1=%b exp=0,1", bus.r0_arready, bus.r1_arready); end
        @(negedge clk);
        bus.r0_arvalid = 1'b0; bus.r1_arvalid = 1'b0; bus.m_arready = 1'b1;
        #1;
        checks++; if (grant !== 2'b10 || bus.m_araddr !== 32'h800) begin failures++; $display("FAIL rr_grant1 got grant=%b addr=%h exp=10,800", grant, bus.m_araddr); end
        @(negedge clk);
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 32'h22; bus.r1_rready = 1'b1;
        #1;
        checks++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== 32'h22 || bus.r0_rvalid !== 1'b0) begin failures++; $display("FAIL rr_beat1 got r1v=%b d=%h r0v=%b exp=1,22,0", bus.r1_rvalid, bus.r1_rdata, bus.r0_rvalid); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rr_end_grant got=%b exp=00", grant); end
        $display("txn round robin r0 then r1 done");
    endtask

    task automatic test_addr_hold();
        @(negedge clk);
        bus.r1_arvalid = 1'b1; bus.r1_araddr = 32'h2000; bus.r1_arlen = 4'd7;
        #1;
        checks++; if (bus.r1_arready !== 1'b1) begin failures++; $display("FAIL hold_accept got=%b exp=1", bus.r1_arready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.r0_arvalid = 1'b1; bus.r1_araddr = 32'hDEAD_0000 + k; bus.r1_arlen = 4'd2;
            #1;
            checks++; if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== 32'h2000 || bus.m_arlen !== 4'd7) begin failures++; $display("FAIL hold_addr%0d got v=%b a=%h l=%0d exp 1,2000,7", k, bus.m_arvalid, bus.m_araddr, bus.m_arlen); end
            checks++; if (bus.r0_arready !== 1'b0 || bus.r1_arready !== 1'b0) begin failures++; $display("FAIL hold_noready%0d got r0=%b r1=%b exp=0,0", k, bus.r0_arready, bus.r1_arready); end
        end
        @(negedge clk);
        bus.r0_arvalid = 1'b0; bus.r1_arvalid = 1'b0; bus.m_arready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rlast = (i == 7);
            bus.m_rdata = 32'hB0 + i; bus.r1_rready = 1'b1;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (grant !== 2'b00 || protocol_err !== 1'b0) begin failures++; $display("FAIL hold_end got grant=%b err=%b exp=00,0", grant, protocol_err); end
        $display("txn address hold r1 len=7 done");
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.r0_arvalid = 1'b1; bus.r0_araddr = 32'h3000; bus.r0_arlen = 4'd3;
        @(negedge clk);
        bus.r0_arvalid = 1'b0; bus.m_arready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hC0 + i; bus.r0_rready = 1'b1;
            #1;
            checks++; if (bus.r0_rvalid !== 1'b1) begin failures++; $display("FAIL flush_pre%0d got=%b exp=1", i, bus.r0_rvalid); end
        end
        @(negedge clk);
        bus.m_rvalid = 1'b0; bus.r0_rready = 1'b0; flush = 1'b1;
        #1;
        checks++; if (bus.m_rready !== 1'b1) begin failures++; $display("FAIL flush_same_cycle got mrr=%b exp=1", bus.m_rready); end
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            flush = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hC0 + i; bus.m_rlast = (i == 3);
            #1;
            checks++; if (bus.r0_rvalid !== 1'b0 || bus.m_rready !== 1'b1) begin failures++; $display("FAIL flush_drain%0d got r0v=%b mrr=%b exp=0,1", i, bus.r0_rvalid, bus.m_rready); end
        end
        @(negedge clk);
        clear_inputs();
        flush = 1'b1; bus.r0_arvalid = 1'b1; bus.r0_araddr = 32'h3100; bus.r0_arlen = 4'd0;
        #1;
        checks++; if (grant !== 2'b00 || bus.r0_arready !== 1'b1) begin failures++; $display("FAIL flush_idle got grant=%b r0rdy=%b exp=00,1", grant, bus.r0_arready); end
        @(negedge clk);
        flush = 1'b0; bus.r0_arvalid = 1'b0; bus.m_arready = 1'b1;
        @(negedge clk);
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 32'hCC; bus.r0_rready = 1'b1;
        #1;
        checks++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 32'hCC) begin failures++; $display("FAIL flush_cleared got v=%b d=%h exp=1,cc", bus.r0_rvalid, bus.r0_rdata); end
        @(negedge clk);
        clear_inputs();
        $display("txn flush drain r0 len=3 done");
    endtask

    task automatic test_protocol_err();
        @(negedge clk);
        bus.r0_arvalid = 1'b1; bus.r0_araddr = 32'h5000; bus.r0_arlen = 4'd3;
        @(negedge clk);
        bus.r0_arvalid = 1'b0; bus.m_arready = 1'b1;
        @(negedge clk);
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.r0_rready = 1'b1;
        @(negedge clk);
        bus.m_rlast = 1'b1;
        #1;
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL perr_before got=%b exp=0", protocol_err); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (protocol_err !== 1'b1 || grant !== 2'b00) begin failures++; $display("FAIL perr_set got err=%b grant=%b exp=1,00", protocol_err, grant); end
        bus.r1_arvalid = 1'b1; bus.r1_arlen = 4'd0;
        @(negedge clk);
        bus.r1_arvalid = 1'b0; bus.m_arready = 1'b1;
        @(negedge clk);
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.r1_rready = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", protocol_err); end
        $display("txn early rlast protocol error done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.r1_arvalid = 1'b1; bus.r1_araddr = 32'h6000; bus.r1_arlen = 4'd3;
        @(negedge clk);
        bus.r1_arvalid = 1'b0; bus.m_arready = 1'b1;
        @(negedge clk);
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77; bus.r1_rready = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.r1_arvalid = 1'b1;
        #1;
        checks++; if (bus.r1_rvalid !== 1'b0 || bus.r1_rdata !== 32'h0 || bus.m_rready !== 1'b0) begin failures++; $display("FAIL rstmid_r got v=%b d=%h mrr=%b exp=0,0,0", bus.r1_rvalid, bus.r1_rdata, bus.m_rready); end
        checks++; if (grant !== 2'b00 || protocol_err !== 1'b0 || bus.r1_arready !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got grant=%b err=%b rdy=%b exp=00,0,0", grant, protocol_err, bus.r1_arready); end
        checks++; if (bus.m_arvalid !== 1'b0 || bus.m_araddr !== 32'h0) begin failures++; $display("FAIL rstmid_m got v=%b a=%h exp=0,0", bus.m_arvalid, bus.m_araddr); end
        @(negedge clk);
        rst = 1'b1; bus.m_rvalid = 1'b0; bus.r1_rready = 1'b0;
        bus.r1_arvalid = 1'b1; bus.r1_araddr = 32'h300; bus.r1_arlen = 4'd1;
        #1;
        checks++; if (bus.r1_arready !== 1'b1) begin failures++; $display("FAIL rstmid_accept got=%b exp=1", bus.r1_arready); end
        @(negedge clk);
        bus.r1_arvalid = 1'b0; bus.m_arready = 1'b1;
        #1;
        checks++; if (bus.m_araddr !== 32'h300 || bus.m_arlen !== 4'd1) begin failures++; $display("FAIL rstmid_addr got=%h/%0d exp=300/1", bus.m_araddr, bus.m_arlen); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hE0 + i;
            bus.m_rlast = (i == 1); bus.r1_rready = 1'b1;
            #1;
            checks++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== 32'hE0 + i) begin failures++; $display("FAIL rstmid_beat%0d got v=%b d=%h exp=1,%h", i, bus.r1_rvalid, bus.r1_rdata, 32'hE0 + i); end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (grant !== 2'b00 || protocol_err !== 1'b0) begin failures++; $display("FAIL rstmid_end got grant=%b err=%b exp=00,0", grant, protocol_err); end
        $display("txn reset mid-burst then r1 len=1 done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_addr_hold();
        test_flush();
        test_protocol_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the single AXI3 read port to memory between the instruction-cache refill controller (requester 0) and the data-cache refill controller (requester 1). It accepts one read-address request at a time, holds the grant for the whole burst, and steers R-channel beats back to the owner. A flush during an I-side burst drains the remaining beats so the bus stays protocol-clean. It sits between the IF/MEM cache controllers and the top-level AXI3 master port.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 4, AXI3 ARLEN width (burst = ARLEN+1 beats, max 16)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; asynchronous, active-low
- r0_araddr / r1_araddr  in  ADDR_W  requester read address
- r0_arlen / r1_arlen  in  LEN_W  requester burst length
- r0_arvalid / r1_arvalid  in  1  request valid
- r0_arready / r1_arready  out  1  request accepted
- r0_rdata / r1_rdata  out  DATA_W  returned beat
- r0_rlast / r1_rlast  out  1  last beat
- r0_rvalid / r1_rvalid  out  1  beat valid
- r0_rready / r1_rready  in  1  requester ready for beat
- flush  in  1  I-side flush; drains in-flight requester-0 burst
- m_araddr  out  ADDR_W,  m_arlen  out  LEN_W,  m_arvalid  out  1,  m_arready  in  1
- m_rdata  in  DATA_W,  m_rlast  in  1,  m_rvalid  in  1,  m_rready  out  1
- grant  out  2  one-hot current owner (00 when idle)
- protocol_err  out  1  sticky: RLAST position did not match latched ARLEN

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: if any rN_arvalid, select winner; assert rN_arready combinationally for winner only; latch araddr, arlen, owner; clear beat counter; go ADDR.
- Arbitration: single requester wins outright. Both valid: grant the requester not granted last (round-robin). last_grant resets to 1, so the first tie after reset goes to requester 0.
- ADDR: m_arvalid=1 with latched address/length; hold stable until m_arready; then go DATA.
- DATA: rOwner_rvalid = m_rvalid & ~drain; rdata/rlast pass through; m_rready = drain ? 1 : rOwner_rready. Non-owner rvalid always 0.
- Beat counter (LEN_W bits) increments on each m_rvalid & m_rready. Beat with m_rlast=1 -> go IDLE, clear grant, update last_grant. If m_rlast arrives with counter != arlen, or counter == arlen without m_rlast, set protocol_err (cleared only by reset); the FSM still exits only on m_rlast.
- drain: set when flush=1 while owner==0 in ADDR or DATA (incl. same cycle); cleared on return to IDLE. flush while idle or owner==1 has no effect. flush in IDLE does not block a requester-0 request in that cycle.
- Reset (any time, incl. mid-burst): FSM→IDLE, all outputs 0, drain=0, protocol_err=0, last_grant=1.

## Timing
- Request accept (arready) in the same cycle as the IDLE arvalid sample; m_arvalid asserted the next cycle.
- Address hold: m_araddr/m_arlen constant from ADDR entry until m_arready handshake.
- R path combinational: zero added latency for beats.
- After the last beat, exactly one IDLE cycle precedes the next arready; minimum turnaround is 1 cycle.
- arready is never asserted outside IDLE; at most one outstanding burst.

## Structure
- Package axi_arb_pkg: state enum (IDLE/ADDR/DATA), requester IDs (REQ_ICACHE=0, REQ_DCACHE=1), default widths.
- One sub-module: rr_arbiter_2 (2-way round-robin pick from valid vector and last_grant, combinational).

## Test plan
- Reset, then r0 request addr 0x100, arlen 3, m_arready at once -> r0_arready in cycle 0, m_arvalid cycle 1, 4 beats to r0 only, grant=01 then 00.
- r0 and r1 valid same cycle after reset -> r0 granted first; on next tie r1 granted (round-robin).
- m_arready held low 5 cycles -> m_araddr/m_arlen stable, no second arready.
- flush during beat 2 of 4 on r0 burst -> r0_rvalid low for beats 3-4, m_rready high, FSM back to IDLE after m_rlast.
- m_rlast on beat 2 with arlen=3 -> protocol_err=1 and sticky until reset; FSM returns to IDLE.
- rst low mid-DATA -> all outputs 0 immediately; after release a new r1 request completes normally.
